// File: rtl/axi2_arb_pkg.sv
// Shared types and constants for the two-master AXI4-Lite to native memory arbiter.
package axi2_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NUM_M          = 2;
  localparam int PROT_W         = 3;
  localparam int PROT_INSTR_BIT = 2;
endpackage

// File: rtl/axi2_native_arbiter_rr_pick2.sv
// Two-way round-robin pick: the master that did not win last time wins a tie.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_idx
);
  assign o_valid = |i_req;
  assign o_idx   = (&i_req) ? ~i_last : i_req[1];
endmodule

// File: rtl/axi2_native_arbiter.sv
// Shares one PicoRV32-style native memory port between two AXI4-Lite masters,
// one transaction in flight: accept (IDLE) -> memory access (MEM) -> response (RESP).
module axi2_native_arbiter
  import axi2_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [1:0]              m_awvalid,
  output logic [1:0]              m_awready,
  input  logic [2*AW-1:0]         m_awaddr,
  input  logic [2*PROT_W-1:0]     m_awprot,
  input  logic [1:0]              m_wvalid,
  output logic [1:0]              m_wready,
  input  logic [2*DW-1:0]         m_wdata,
  input  logic [2*(DW/8)-1:0]     m_wstrb,
  output logic [1:0]              m_bvalid,
  input  logic [1:0]              m_bready,
  input  logic [1:0]              m_arvalid,
  output logic [1:0]              m_arready,
  input  logic [2*AW-1:0]         m_araddr,
  input  logic [2*PROT_W-1:0]     m_arprot,
  output logic [1:0]              m_rvalid,
  input  logic [1:0]              m_rready,
  output logic [DW-1:0]           m_rdata,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  output logic [DW/8-1:0]         mem_wstrb,
  output logic                    mem_instr,
  input  logic [DW-1:0]           mem_rdata,
  output logic                    grant
);
  localparam int SW = DW / 8;

  state_t          r_state, w_state_nxt;
  logic            r_grant;
  logic            r_is_wr;
  logic            r_instr;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [SW-1:0]   r_wstrb;
  logic [DW-1:0]   r_rdata;

  logic [1:0]      w_wreq, w_req;
  logic            w_valid, w_idx, w_win_wr, w_accept, w_resp_done;
  logic [AW-1:0]   w_awaddr, w_araddr;
  logic [DW-1:0]   w_wdata;
  logic [SW-1:0]   w_wstrb;
  logic            w_fetch;
  logic            w_unused;

  // A write needs both AW and W; a lone half just waits.
  assign w_wreq = m_awvalid & m_wvalid;
  assign w_req  = w_wreq | m_arvalid;

  rr_pick2 u_pick (
    .i_req   (w_req),
    .i_last  (r_grant),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_win_wr = w_wreq[w_idx];
  assign w_accept = resetn && (r_state == IDLE) && w_valid;

  assign w_awaddr = w_idx ? m_awaddr[2*AW-1:AW] : m_awaddr[AW-1:0];
  assign w_araddr = w_idx ? m_araddr[2*AW-1:AW] : m_araddr[AW-1:0];
  assign w_wdata  = w_idx ? m_wdata[2*DW-1:DW]  : m_wdata[DW-1:0];
  assign w_wstrb  = w_idx ? m_wstrb[2*SW-1:SW]  : m_wstrb[SW-1:0];
  assign w_fetch  = w_idx ? m_arprot[PROT_W+PROT_INSTR_BIT] : m_arprot[PROT_INSTR_BIT];

  assign w_resp_done = r_is_wr ? m_bready[r_grant] : m_rready[r_grant];

  assign w_unused = ^{m_awprot, m_arprot[PROT_W+1:PROT_W], m_arprot[1:0]};

  always_comb begin
    w_state_nxt = r_state;
    m_awready   = '0;
    m_wready    = '0;
    m_arready   = '0;
    m_bvalid    = '0;
    m_rvalid    = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = MEM;
          if (w_win_wr) begin
            m_awready[w_idx] = 1'b1;
            m_wready[w_idx]  = 1'b1;
          end else begin
            m_arready[w_idx] = 1'b1;
          end
        end
      end
      MEM: begin
        if (mem_ready) w_state_nxt = RESP;
      end
      RESP: begin
        if (r_is_wr) m_bvalid[r_grant] = 1'b1;
        else         m_rvalid[r_grant] = 1'b1;
        if (w_resp_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_grant <= 1'b1;
      r_is_wr <= 1'b0;
      r_instr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_grant <= w_idx;
        r_is_wr <= w_win_wr;
        r_addr  <= w_win_wr ? w_awaddr : w_araddr;
        r_wdata <= w_win_wr ? w_wdata  : '0;
        r_wstrb <= w_win_wr ? w_wstrb  : '0;
        r_instr <= w_win_wr ? 1'b0     : w_fetch;
      end
      // Fetch flag is only meaningful while the request is on the bus.
      if ((r_state == MEM) && mem_ready) begin
        r_instr <= 1'b0;
        if (!r_is_wr) r_rdata <= mem_rdata;
      end
    end
  end

  assign mem_valid = (r_state == MEM);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign mem_instr = r_instr;
  assign m_rdata   = r_rdata;
  assign grant     = r_grant;
endmodule

// File: doc/axi2_native_arbiter.md
Name: axi2_native_arbiter

Overview:
Shares one native PicoRV32-style memory port (mem_valid/mem_ready) between two AXI4-Lite masters, for example two picorv32_axi cores. It holds at most one transaction in flight. Masters are granted in round-robin order, and each transaction is sequenced through accept, memory access and response delivery. It sits between the cores and a single memory or peripheral bus in dual-core SoCs and formal harnesses.

Parameters:
AW, 32, address width
DW, 32, data width (multiple of 8)

Ports:
clk  in  1  clock
resetn  in  1  reset
m_awvalid  in  2  per-master write-address valid (bit i = master i)
m_awready  out  2  write-address ready
m_awaddr  in  2*AW  write addresses, master i at [i*AW +: AW]
m_awprot  in  6  write prot, 3 bits per master; ignored
m_wvalid  in  2  write-data valid
m_wready  out  2  write-data ready
m_wdata  in  2*DW  write data
m_wstrb  in  2*DW/8  write strobes
m_bvalid  out  2  write response valid
m_bready  in  2  write response ready
m_arvalid  in  2  read-address valid
m_arready  out  2  read-address ready
m_araddr  in  2*AW  read addresses
m_arprot  in  6  read prot; bit 2 = instruction fetch
m_rvalid  out  2  read data valid
m_rready  in  2  read data ready
m_rdata  out  DW  read data, broadcast to both masters
mem_valid  out  1  memory request
mem_ready  in  1  memory done, single-cycle pulse
mem_addr  out  AW  request address
mem_wdata  out  DW  write data
mem_wstrb  out  DW/8  byte enables; 0 = read
mem_instr  out  1  fetch flag
mem_rdata  in  DW  read data, valid with mem_ready
grant  out  1  index of the current or last granted master

Behaviour:
- Clock is clk. Reset is resetn, synchronous, active-low.
- Reset values:
  - state = IDLE; all m_*ready, m_bvalid, m_rvalid and mem_valid = 0.
  - mem_addr, mem_wdata, mem_wstrb, mem_instr and m_rdata = 0.
  - grant = 1, so master 0 has first priority.
- Request conditions:
  - Write request for master i: m_awvalid[i] && m_wvalid[i]. A lone AW or lone W is not a request; it waits.
  - Read request for master i: m_arvalid[i].
  - If one master has both a read and a write request, the write wins.
- Arbitration in IDLE, cycle N:
  - If both masters request, the winner is !grant. If only one requests, it wins.
  - For the winner in cycle N, combinationally: m_awready and m_wready = 1 for a write; m_arready = 1 for a read.
  - No ready is raised outside IDLE, for the loser, or while resetn = 0.
  - At the N edge the arbiter registers grant, addr, wdata, wstrb (0 for reads) and instr (m_arprot[3*g+2] for reads, 0 for writes), then enters MEM.
- MEM state:
  - mem_valid = 1, starting at cycle N+1. All mem_* outputs are held stable until mem_ready.
  - On mem_ready:
    - For a read, latch mem_rdata into m_rdata.
    - Enter RESP.
- RESP state:
  - m_rvalid[grant] (read) or m_bvalid[grant] (write) = 1.
  - The response and m_rdata are held until the matching m_rready/m_bready. Then return to IDLE.
  - New arbitration can occur in that IDLE cycle.
- Minimum turnaround: accept at N, mem_valid at N+1, mem_ready at N+1, response at N+2, ready at N+2, next accept at N+3.
- Ignored inputs:
  - mem_ready outside MEM.
  - m_bready and m_rready outside RESP.
  - The ungranted master's ready inputs.
- m_rdata changes only on a read completion.
- Reset mid-transaction aborts it: no response is delivered and mem_valid drops on the reset edge.
- The grant register is updated only on acceptance, so it alternates under continuous contention.

Decomposition:
- Shared package axi2_arb_pkg: state enum {IDLE, MEM, RESP}; constant PROT_INSTR_BIT = 2; localparams for the slice widths.
- One sub-module, rr_pick2, is natural. It is combinational: inputs req[1:0] and last, outputs valid and idx.
- The FSM and the datapath registers stay in the top module.

Test Plan:
- Master 0 reads 0x100 alone; memory returns 0xDEADBEEF with a 2-cycle mem_ready delay -> m_arready[0] for one cycle; mem_addr = 0x100, mem_wstrb = 0; m_rvalid[0] with m_rdata = 0xDEADBEEF; grant = 0.
- Both masters issue reads in the same cycle after reset -> master 0 is served first, then master 1; mem_addr sequence is m0 addr then m1 addr; grant goes 0 then 1.
- Master 1 writes 0x55AA to 0x20 with wstrb 0x3; AW is asserted 2 cycles before W -> no accept until both are valid; then mem_wdata = 0x55AA, mem_wstrb = 0x3; m_bvalid[1] is held 3 cycles until m_bready[1].
- Master 0 issues an instruction fetch (arprot = 3'b100) while master 1 holds a write -> mem_instr = 1 only during the fetch's MEM phase; round-robin alternates over 4 back-to-back contended transactions.
- resetn is pulled low while in MEM -> the next cycle shows mem_valid = 0, no m_rvalid/m_bvalid, and grant = 1; after reset the first contended request goes to master 0.
